// File: rtl/prio_enc_arb_if.sv
// ============================================================================
// prio_enc_arb_if : request/result bundle for prio_enc_arb
// Rev 1.0
// ============================================================================
`default_nettype none

interface prio_enc_arb_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         en;
  logic [N-1:0] req;
  logic         ready;
  logic         valid;
  logic [W-1:0] idx;
  logic [N-1:0] grant;

  modport master (
    output en, req, ready,
    input  valid, idx, grant
  );

  modport slave (
    input  en, req, ready,
    output valid, idx, grant
  );
endinterface

`default_nettype wire

// File: rtl/prio_enc_arb.sv
// ============================================================================
// prio_enc_arb : registered priority encoder / arbiter, fixed or round-robin
// Rev 1.0
// ============================================================================
`default_nettype none

module prio_enc_arb #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  prio_enc_arb_if.slave  bus
);
  localparam int W = $clog2(N);

  logic         load;
  logic [W-1:0] win;

  // A held, unaccepted result blocks sampling; requesters keep req asserted.
  assign load = bus.en && (|bus.req) && (!bus.valid || bus.ready);

  generate
    if (MODE == 0) begin : g_fixed
      always_comb begin
        win = '0;
        for (int i = 0; i < N; i++) begin
          if (bus.req[i]) win = W'(i);
        end
      end
    end else begin : g_rr
      logic [W-1:0] ptr;

      // The winner drops to lowest priority: the next search starts just below it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ptr <= W'(N - 1);
        end else if (load) begin
          ptr <= (win == '0) ? W'(N - 1) : win - W'(1);
        end
      end

      always_comb begin : p_search
        int   c;
        logic found;
        win   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
          c = int'(ptr) - k;
          if (c < 0) c = c + N;
          if (!found && bus.req[W'(c)]) begin
            found = 1'b1;
            win   = W'(c);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid <= 1'b0;
      bus.idx   <= '0;
      bus.grant <= '0;
    end else if (load) begin
      bus.valid <= 1'b1;
      bus.idx   <= win;
      bus.grant <= {{(N-1){1'b0}}, 1'b1} << win;
    end else if (bus.valid && bus.ready) begin
      bus.valid <= 1'b0;
      bus.idx   <= '0;
      bus.grant <= '0;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_prio_enc_arb.sv
// ============================================================================
// tb_prio_enc_arb : four arbiter configurations driven together, scoreboarded
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prio_enc_arb;
  localparam int ND = 4;  // 0: N8 fixed, 1: N8 rr, 2: N5 rr, 3: N5 fixed

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic       ready = 1'b0;

  logic       v_valid [ND];
  logic [7:0] v_idx   [ND];
  logic [7:0] v_grant [ND];

  int   exp_q [ND][$];
  logic m_valid [ND];
  int   m_ptr [ND];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  function automatic int n_of(int d);
    return (d < 2) ? 8 : 5;
  endfunction

  function automatic int mode_of(int d);
    return (d == 1 || d == 2) ? 1 : 0;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int GN = (g < 2) ? 8 : 5;
    localparam int GM = (g == 1 || g == 2) ? 1 : 0;
    prio_enc_arb_if #(.N(GN)) bus ();
    prio_enc_arb #(.N(GN), .MODE(GM)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.en     = en;
    assign bus.req    = req[GN-1:0];
    assign bus.ready  = ready;
    assign v_valid[g] = bus.valid;
    assign v_idx[g]   = 8'(bus.idx);
    assign v_grant[g] = 8'(bus.grant);
  end

  task automatic check(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic int model_win(input int n, input int mode, input int ptr, input logic [7:0] r);
    int p;
    if (mode == 0) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
      return -1;
    end
    p = ptr;
    for (int k = 0; k < n; k++) begin
      if (r[p]) return p;
      p = (p == 0) ? n - 1 : p - 1;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      exp_q[d].delete();
      m_valid[d] = 1'b0;
      m_ptr[d]   = n_of(d) - 1;
    end
  endtask

  // Apply one cycle of inputs; expected results are queued as they are loaded.
  task automatic drive(input logic e, input logic [7:0] r, input logic rd);
    logic nv [ND];
    en = e; req = r; ready = rd;
    for (int d = 0; d < ND; d++) begin
      logic [7:0] mr;
      int w;
      mr = r & ((n_of(d) == 8) ? 8'hFF : 8'h1F);
      if (e && (mr != 8'h00) && (!m_valid[d] || rd)) begin
        w = model_win(n_of(d), mode_of(d), m_ptr[d], mr);
        exp_q[d].push_back(w);
        m_ptr[d] = (w == 0) ? n_of(d) - 1 : w - 1;
        nv[d] = 1'b1;
      end else if (m_valid[d] && rd) begin
        nv[d] = 1'b0;
      end else begin
        nv[d] = m_valid[d];
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) m_valid[d] = nv[d];
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; req = '0; ready = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: per-cycle invariants, and a scoreboard pop on every accepted result.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      check("valid", d, 8'(v_valid[d]), 8'(m_valid[d]));
      if (v_valid[d]) begin
        check("grant_onehot", d, v_grant[d], 8'd1 << v_idx[d]);
        check("idx_range", d, 8'(v_idx[d] < 8'(n_of(d))), 8'd1);
      end else begin
        check("idle_idx", d, v_idx[d], 8'd0);
        check("idle_grant", d, v_grant[d], 8'd0);
      end
      if (v_valid[d] && ready && !rst) begin
        if (exp_q[d].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result dut%0d: got idx %0d, expected no result", d, v_idx[d]);
        end else begin
          int e;
          e = exp_q[d].pop_front();
          check("result_idx", d, v_idx[d], 8'(e));
          check("result_grant", d, v_grant[d], 8'd1 << e);
        end
      end
    end
  end

  initial begin
    int rr8 [9];
    int rr5 [9];
    rr8 = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    rr5 = '{4, 3, 2, 1, 0, 4, 3, 2, 1};
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Asynchronous reset while results are held
    drive(1'b1, 8'h96, 1'b0);
    check("held_before_rst", 0, v_idx[0], 8'd7);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      check("async_rst_valid", d, 8'(v_valid[d]), 8'd0);
      check("async_rst_idx", d, v_idx[d], 8'd0);
      check("async_rst_grant", d, v_grant[d], 8'd0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(1'b1, 8'h05, 1'b1);
    check("rr_after_reset", 1, v_idx[1], 8'd2);

    // Fixed priority
    do_reset();
    drive(1'b1, 8'h96, 1'b1);
    check("fixed_idx", 0, v_idx[0], 8'd7);
    check("fixed_grant", 0, v_grant[0], 8'h80);
    check("fixed_n5", 3, v_idx[3], 8'd4);
    drive(1'b1, 8'h06, 1'b1);
    check("fixed_idx2", 0, v_idx[0], 8'd2);
    drive(1'b0, 8'h06, 1'b1);
    check("en_off_valid", 0, 8'(v_valid[0]), 8'd0);
    check("en_off_idx", 0, v_idx[0], 8'd0);

    // Round-robin fairness
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'hFF, 1'b1);
      check("rr8_seq", 1, v_idx[1], 8'(rr8[i]));
      check("rr5_seq", 2, v_idx[2], 8'(rr5[i]));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h22, 1'b1);
      check("rr_alt", 1, v_idx[1], (i % 2 == 0) ? 8'd5 : 8'd1);
    end

    // Backpressure
    do_reset();
    drive(1'b1, 8'h11, 1'b1);
    check("bp_load", 1, v_idx[1], 8'd4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h80, 1'b0);
      check("bp_hold_idx", 1, v_idx[1], 8'd4);
      check("bp_hold_valid", 1, 8'(v_valid[1]), 8'd1);
    end
    drive(1'b1, 8'h11, 1'b1);
    check("bp_release", 1, v_idx[1], 8'd0);

    // Non-power-of-two fixed mode
    do_reset();
    drive(1'b1, 8'h10, 1'b1);
    check("n5_fixed_top", 3, v_idx[3], 8'd4);
    check("n5_rr_top", 2, v_idx[2], 8'd4);

    // Degenerate inputs and simultaneous pop/load
    drive(1'b1, 8'h00, 1'b1);
    for (int d = 0; d < ND; d++) check("zero_req_valid", d, 8'(v_valid[d]), 8'd0);
    drive(1'b1, 8'h03, 1'b1);
    check("popload_a", 0, v_idx[0], 8'd1);
    drive(1'b1, 8'h0C, 1'b1);
    check("popload_valid", 0, 8'(v_valid[0]), 8'd1);
    check("popload_b", 0, v_idx[0], 8'd3);

    // Random traffic
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      drive($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0);
    end

    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    for (int d = 0; d < ND; d++) check("queue_empty", d, 8'(exp_q[d].size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
